// File: rtl/imem_if.sv
// Boot-load and fetch bundle of the instruction memory responder.
// master = host/PC side, slave = responder.
interface imem_if;
    logic        load_en;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        load_done;
    logic        req;
    logic [6:0]  addr;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_misaligned;

    modport master (
        output load_en, load_valid, load_byte, req, addr,
        input  load_ready, load_done, rsp_valid, rsp_instr, rsp_misaligned
    );

    modport slave (
        input  load_en, load_valid, load_byte, req, addr,
        output load_ready, load_done, rsp_valid, rsp_instr, rsp_misaligned
    );
endinterface

// File: rtl/imem_responder.sv
// Byte-loaded instruction memory with a one-cycle-latency fetch port.
// Loads little-endian bytes in LOAD; serves fetches only in RUN.
module imem_responder #(
    parameter int          DEPTH = 32,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic   clk,
    input  logic   reset,
    imem_if.slave  bus
);
    typedef enum logic [1:0] {S_WAIT, S_LOAD, S_RUN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_en_q;
    logic [1:0]  r_bcnt;
    logic [4:0]  r_wptr;
    logic [23:0] r_buf;
    logic [31:0] r_mem [DEPTH];
    logic        r_rsp_valid;
    logic        r_rsp_mis;
    logic [31:0] r_rsp_instr;

    logic        w_rise;
    logic        w_load_ready;
    logic        w_load_done;
    logic        w_accept;
    logic        w_word_done;
    logic        w_last;
    logic        w_enter;
    logic        w_fire;
    logic        w_mis;
    logic [4:0]  w_idx;
    logic [31:0] w_word;
    logic [31:0] w_rd;

    assign w_rise      = bus.load_en & ~r_en_q;
    assign w_accept    = bus.load_valid & w_load_ready;
    assign w_word_done = w_accept & (r_bcnt == 2'd3);
    assign w_last      = w_word_done & (r_wptr == 5'(DEPTH - 1));
    assign w_enter     = (r_state != S_LOAD) & (w_next == S_LOAD);
    assign w_word      = {bus.load_byte, r_buf};
    assign w_fire      = bus.req & (r_state == S_RUN);
    assign w_idx       = bus.addr[6:2];
    assign w_mis       = bus.addr[1:0] != 2'b00;
    assign w_rd        = (32'(w_idx) < 32'(DEPTH)) ? r_mem[w_idx] : NOP;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WAIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WAIT:  if (w_rise) w_next = S_LOAD;
            S_LOAD:  if (!bus.load_en || w_last) w_next = S_RUN;
            S_RUN:   if (w_rise) w_next = S_LOAD;
            default: w_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        w_load_done  = 1'b0;
        unique case (r_state)
            S_LOAD:  w_load_ready = 1'b1;
            S_RUN:   w_load_done  = 1'b1;
            default: ;
        endcase
    end

    // Counters restart on LOAD entry, which also drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_q <= 1'b0;
            r_bcnt <= 2'd0;
            r_wptr <= 5'd0;
            r_buf  <= 24'd0;
        end else begin
            r_en_q <= bus.load_en;
            if (w_enter) begin
                r_bcnt <= 2'd0;
                r_wptr <= 5'd0;
            end else if (w_accept) begin
                r_bcnt <= r_bcnt + 2'd1;
                if (w_word_done) r_wptr <= r_wptr + 5'd1;
                else r_buf[{r_bcnt, 3'b000} +: 8] <= bus.load_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= NOP;
        end else if (w_word_done && (32'(r_wptr) < 32'(DEPTH))) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_mis   <= 1'b0;
            r_rsp_instr <= 32'd0;
        end else begin
            r_rsp_valid <= w_fire;
            r_rsp_mis   <= w_fire & w_mis;
            r_rsp_instr <= !w_fire ? 32'd0 : (w_mis ? NOP : w_rd);
        end
    end

    assign bus.load_ready     = w_load_ready;
    assign bus.load_done      = w_load_done;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_instr      = r_rsp_instr;
    assign bus.rsp_misaligned = r_rsp_mis;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed table,
// hand-written load/fetch sequences, random traffic vs a model.
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_if bus ();
    imem_responder dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          r, len, lv;
        logic [7:0]  lb;
        bit          rq;
        logic [6:0]  ad;
        bit          e_rdy, e_done, e_val;
        logic [31:0] e_ins;
        bit          e_mis;
    } vec_t;

    // Reference model: mode 0 idle, 1 loading, 2 running.
    int          m_mode;
    bit          m_prev;
    logic [31:0] m_mem [32];
    logic [7:0]  m_q [$];
    int          m_wp;
    bit          e_val, e_mis;
    logic [31:0] e_ins;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit len, bit lv, logic [7:0] lb,
                              bit rq, logic [6:0] ad);
        if (r) begin
            m_mode = 0; m_prev = 0; m_wp = 0;
            m_q.delete();
            foreach (m_mem[i]) m_mem[i] = NOP;
            e_val = 0; e_mis = 0; e_ins = 0;
            return;
        end
        e_val = rq && (m_mode == 2);
        e_mis = e_val && (ad[1:0] != 2'b00);
        e_ins = !e_val ? 32'd0 : (e_mis ? NOP : m_mem[ad[6:2]]);
        if (m_mode == 1) begin
            if (lv) begin
                m_q.push_back(lb);
                if (m_q.size() == 4) begin
                    m_mem[m_wp] = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_wp++;
                    m_q.delete();
                end
            end
            if (!len || m_wp == 32) m_mode = 2;
        end else if (len && !m_prev) begin
            m_mode = 1; m_wp = 0;
            m_q.delete();
        end
        m_prev = len;
    endtask

    task automatic drive(bit r, bit len, bit lv, logic [7:0] lb,
                         bit rq, logic [6:0] ad);
        reset = r;
        bus.load_en = len;
        bus.load_valid = lv;
        bus.load_byte = lb;
        bus.req = rq;
        bus.addr = ad;
    endtask

    task automatic apply(string nm, bit r, bit len, bit lv, logic [7:0] lb,
                         bit rq, logic [6:0] ad);
        drive(r, len, lv, lb, rq, ad);
        model_step(r, len, lv, lb, rq, ad);
        @(posedge clk);
        #1;
        chk({nm, ".ready"}, 32'(bus.load_ready), 32'(m_mode == 1));
        chk({nm, ".done"},  32'(bus.load_done),  32'(m_mode == 2));
        chk({nm, ".valid"}, 32'(bus.rsp_valid),  32'(e_val));
        chk({nm, ".instr"}, bus.rsp_instr,       e_ins);
        chk({nm, ".mis"},   32'(bus.rsp_misaligned), 32'(e_mis));
    endtask

    function automatic vec_t mk(bit r, bit len, bit lv, logic [7:0] lb,
                                bit rq, logic [6:0] ad, bit rdy, bit dn,
                                bit v, logic [31:0] ins, bit mis);
        vec_t t;
        t.r = r; t.len = len; t.lv = lv; t.lb = lb; t.rq = rq; t.ad = ad;
        t.e_rdy = rdy; t.e_done = dn; t.e_val = v; t.e_ins = ins;
        t.e_mis = mis;
        return t;
    endfunction

    vec_t        tv [16];
    logic [31:0] img [32];
    logic [7:0]  b;
    bit          len_r;

    initial begin
        drive(1, 0, 0, 8'h00, 0, 7'd0);

        tv[0]  = mk(1,0,0,8'h00,0,7'd0,  0,0,0,32'h0,0);
        tv[1]  = mk(0,1,0,8'h00,0,7'd0,  1,0,0,32'h0,0);
        tv[2]  = mk(0,1,1,8'h13,0,7'd0,  1,0,0,32'h0,0);
        tv[3]  = mk(0,1,1,8'h05,0,7'd0,  1,0,0,32'h0,0);
        tv[4]  = mk(0,1,1,8'h50,0,7'd0,  1,0,0,32'h0,0);
        tv[5]  = mk(0,1,1,8'h00,0,7'd0,  1,0,0,32'h0,0);
        tv[6]  = mk(0,0,0,8'h00,0,7'd0,  0,1,0,32'h0,0);
        tv[7]  = mk(0,0,0,8'h00,1,7'd0,  0,1,1,32'h00500513,0);
        tv[8]  = mk(0,0,0,8'h00,1,7'd6,  0,1,1,NOP,1);
        tv[9]  = mk(0,0,0,8'h00,1,7'd4,  0,1,1,NOP,0);
        tv[10] = mk(0,0,0,8'h00,0,7'd0,  0,1,0,32'h0,0);
        tv[11] = mk(0,1,0,8'h00,1,7'd0,  1,0,1,32'h00500513,0);
        tv[12] = mk(0,1,0,8'h00,1,7'd0,  1,0,0,32'h0,0);
        tv[13] = mk(0,0,0,8'h00,0,7'd0,  0,1,0,32'h0,0);
        tv[14] = mk(1,0,0,8'h00,1,7'd0,  0,0,0,32'h0,0);
        tv[15] = mk(0,0,0,8'h00,1,7'd0,  0,0,0,32'h0,0);

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].r, tv[i].len, tv[i].lv, tv[i].lb, tv[i].rq, tv[i].ad);
            model_step(tv[i].r, tv[i].len, tv[i].lv, tv[i].lb,
                       tv[i].rq, tv[i].ad);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d.ready", i), 32'(bus.load_ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d.done", i),  32'(bus.load_done),  32'(tv[i].e_done));
            chk($sformatf("tv%0d.valid", i), 32'(bus.rsp_valid),  32'(tv[i].e_val));
            chk($sformatf("tv%0d.instr", i), bus.rsp_instr,       tv[i].e_ins);
            chk($sformatf("tv%0d.mis", i),   32'(bus.rsp_misaligned), 32'(tv[i].e_mis));
        end

        // Full image with load_en held high: exits on the last word.
        apply("full.rst", 1, 0, 0, 8'h00, 0, 7'd0);
        apply("full.go", 0, 1, 0, 8'h00, 0, 7'd0);
        for (int w = 0; w < 32; w++) begin
            img[w] = $urandom;
            for (int k = 0; k < 4; k++) begin
                b = img[w][8*k +: 8];
                apply("full.byte", 0, 1, 1, b, 0, 7'd0);
            end
        end
        chk("full.ready_drop", 32'(bus.load_ready), 32'd0);
        chk("full.done", 32'(bus.load_done), 32'd1);
        apply("full.extra", 0, 1, 1, 8'hAA, 0, 7'd0);
        chk("full.no_reload", 32'(bus.load_ready), 32'd0);
        for (int w = 0; w < 32; w++) begin
            apply("full.fetch", 0, 1, 0, 8'h00, 1, 7'(w * 4));
            chk($sformatf("full.word%0d", w), bus.rsp_instr, img[w]);
        end

        // Six bytes then drop load_en: partial word1 discarded.
        apply("part.rst", 1, 0, 0, 8'h00, 0, 7'd0);
        apply("part.go", 0, 1, 0, 8'h00, 0, 7'd0);
        for (int k = 0; k < 6; k++)
            apply("part.byte", 0, 1, 1, 8'(8'h11 * (k + 1)), 0, 7'd0);
        apply("part.stop", 0, 0, 0, 8'h00, 0, 7'd0);
        apply("part.f0", 0, 0, 0, 8'h00, 1, 7'd0);
        chk("part.word0", bus.rsp_instr, 32'h44332211);
        apply("part.f4", 0, 0, 0, 8'h00, 1, 7'd4);
        chk("part.word1", bus.rsp_instr, NOP);

        // Reset in the middle of word3, then an empty load.
        apply("mid.rst", 1, 0, 0, 8'h00, 0, 7'd0);
        apply("mid.go", 0, 1, 0, 8'h00, 0, 7'd0);
        for (int k = 0; k < 14; k++)
            apply("mid.byte", 0, 1, 1, 8'($urandom), 0, 7'd0);
        apply("mid.reset", 1, 1, 1, 8'h77, 1, 7'd0);
        chk("mid.ready", 32'(bus.load_ready), 32'd0);
        chk("mid.done", 32'(bus.load_done), 32'd0);
        apply("mid.go2", 0, 1, 0, 8'h00, 0, 7'd0);
        apply("mid.stop", 0, 0, 0, 8'h00, 0, 7'd0);
        for (int w = 0; w < 32; w++) begin
            apply("mid.fetch", 0, 0, 0, 8'h00, 1, 7'(w * 4));
            chk($sformatf("mid.nop%0d", w), bus.rsp_instr, NOP);
        end

        // Random traffic against the model.
        len_r = 0;
        for (int c = 0; c < 4000; c++) begin
            if (len_r) begin
                if ($urandom_range(0, 199) == 0) len_r = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                len_r = 1;
            end
            apply("rnd", $urandom_range(0, 299) == 0, len_r,
                  ($urandom % 4) != 0, 8'($urandom), 1'($urandom),
                  7'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
